// File: rtl/matrix_stream_host.sv
`default_nettype none
// ============================================================================
// Module   : matrix_stream_host
// Purpose  : Host-side streaming engine for the 4x4 matrix-multiply
//            accelerator. Buffers operands A and B written by the host,
//            streams them to the multiplier as 8 load beats, drains the
//            4 result columns into a local buffer and pulses done.
// Ports    : clk, reset         - clock, synchronous active-high reset
//            host_we/sel/addr/wdata - operand element write (IDLE only)
//            host_raddr/rdata   - registered result column read
//            start/busy/done/error - job control and status
//            mm_rdata/mm_read_en - load stream to the multiplier
//            mm_wdata/mm_write_ready/mm_write_en - result drain stream
// Revision : 1.0 - initial release
// ============================================================================
module matrix_stream_host #(
  parameter int WIDTH        = 8,
  parameter int MATRIX_WIDTH = 4,
  parameter int RES_W        = 2 * WIDTH,
  parameter int TIMEOUT      = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 host_we,
  input  logic                 host_sel,
  input  logic [3:0]           host_addr,
  input  logic [WIDTH-1:0]     host_wdata,
  input  logic [1:0]           host_raddr,
  output logic [4*RES_W-1:0]   host_rdata,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [4*WIDTH-1:0]   mm_rdata,
  output logic                 mm_read_en,
  input  logic [4*RES_W-1:0]   mm_wdata,
  input  logic                 mm_write_ready,
  output logic                 mm_write_en
);

  localparam int ELEMS = MATRIX_WIDTH * MATRIX_WIDTH;
  localparam int TO_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q;
  logic [2:0]            beat_q;
  logic [1:0]            col_q;
  logic [TO_W-1:0]       to_q;

  logic [WIDTH-1:0]      a_q [ELEMS];
  logic [WIDTH-1:0]      b_q [ELEMS];
  logic [WIDTH-1:0]      a_d [ELEMS];
  logic [WIDTH-1:0]      b_d [ELEMS];
  logic [4*RES_W-1:0]    r_q [4];

  logic [4*RES_W-1:0]    host_rdata_q;
  logic [4*WIDTH-1:0]    mm_rdata_q;
  logic                  mm_read_en_q;
  logic                  mm_write_en_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  error_q;

  logic                  wr_ok;
  logic [2:0]            beat_idx;
  logic [3:0]            addr_hi;
  logic [3:0]            addr_lo;
  logic [4*WIDTH-1:0]    beat_d;

  assign wr_ok = host_we && (state_q == S_IDLE);

  // Next-state operand buffers. Load beats are built from these rather than
  // from the registers so a write coincident with start lands in beat 0.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (wr_ok) begin
      if (host_sel) b_d[host_addr] = host_wdata;
      else          a_d[host_addr] = host_wdata;
    end
  end

  // Beat n: column n>>1, row pair 2*(n&1); element index is row*4 + col.
  assign beat_idx = (state_q == S_IDLE) ? 3'd0 : beat_q + 3'd1;
  assign addr_hi  = {beat_idx[0], 1'b0, beat_idx[2:1]};
  assign addr_lo  = {beat_idx[0], 1'b1, beat_idx[2:1]};
  assign beat_d   = {a_d[addr_hi], a_d[addr_lo], b_d[addr_hi], b_d[addr_lo]};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ELEMS; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) host_rdata_q <= '0;
    else       host_rdata_q <= r_q[host_raddr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      beat_q        <= '0;
      col_q         <= '0;
      to_q          <= '0;
      mm_rdata_q    <= '0;
      mm_read_en_q  <= 1'b0;
      mm_write_en_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      for (int k = 0; k < 4; k++) r_q[k] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            error_q      <= 1'b0;
            beat_q       <= '0;
            col_q        <= '0;
            to_q         <= '0;
            mm_rdata_q   <= beat_d;
            mm_read_en_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (beat_q == 3'd7) begin
            // mm_rdata keeps beat 7 on the bus after the load phase.
            mm_read_en_q  <= 1'b0;
            mm_write_en_q <= 1'b1;
            to_q          <= '0;
            state_q       <= S_DRAIN;
          end else begin
            beat_q     <= beat_q + 3'd1;
            mm_rdata_q <= beat_d;
          end
        end

        S_DRAIN: begin
          if (mm_write_ready) begin
            r_q[col_q] <= mm_wdata;
            to_q       <= '0;
            if (col_q == 2'd3) begin
              mm_write_en_q <= 1'b0;
              done_q        <= 1'b1;
              state_q       <= S_DONE;
            end else begin
              col_q <= col_q + 2'd1;
            end
          end else if (to_q == TO_LAST) begin
            // Abort: partially captured columns stay in the result buffer.
            error_q       <= 1'b1;
            mm_write_en_q <= 1'b0;
            busy_q        <= 1'b0;
            state_q       <= S_IDLE;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign host_rdata  = host_rdata_q;
  assign mm_rdata    = mm_rdata_q;
  assign mm_read_en  = mm_read_en_q;
  assign mm_write_en = mm_write_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule
`default_nettype wire
